// File: rtl/textmode_writer.sv
// textmode_writer: byte-stream front end for the text-mode display memory CPU port.
// Optional feature macro: TEXTMODE_WRITER_SCROLL_EN (defined: last-row overflow
// scrolls the screen up; undefined: it wraps to row 0 and blanks that row).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            byte handshake; in_chr/in_att latched on accept
//   busy                         high whenever an operation is in progress
//   cur_row/cur_col              hardware cursor
//   mem_row/mem_col/mem_en/mem_wr/mem_wr_data/mem_rd_data  display memory port
module textmode_writer #(
   parameter int ROWS = 30,
   parameter int COLS = 80,
   parameter logic [7:0] BLANK_CHR = 8'h20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_chr,
   input  logic [7:0]  in_att,
   output logic        busy,
   output logic [4:0]  cur_row,
   output logic [6:0]  cur_col,
   output logic [4:0]  mem_row,
   output logic [6:0]  mem_col,
   output logic [15:0] mem_wr_data,
   input  logic [15:0] mem_rd_data,
   output logic        mem_en,
   output logic        mem_wr
);
   localparam logic [4:0] RL = 5'(ROWS - 1);
   localparam logic [6:0] CL = 7'(COLS - 1);
   typedef enum logic [2:0] {
      IDLE, PUT, NEWLINE, CLEAR
`ifdef TEXTMODE_WRITER_SCROLL_EN
      , SC_RD, SC_WR
`endif
   } state_t;
   state_t      state;
   logic [7:0]  att;
   logic [15:0] wd;
   logic [4:0]  r, clr_end, fin_row;
   logic [6:0]  c;
`ifdef TEXTMODE_WRITER_SCROLL_EN
   // The scroll copy writes the word the memory returns this cycle for the
   // read issued in the previous cycle, so the data bypasses wd here.
   assign mem_wr_data = (state == SC_WR) ? mem_rd_data : wd;
`else
   assign mem_wr_data = wd;
   logic unused_rd;
   assign unused_rd = ^mem_rd_data;
`endif
   // Memory port signals are registered: each transition sets up the access
   // performed during the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_row  <= '0;
         cur_col  <= '0;
         mem_en   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_row  <= '0;
         mem_col  <= '0;
         wd       <= '0;
         busy     <= 1'b0;
         in_ready <= 1'b1;
         att      <= '0;
         r        <= '0;
         c        <= '0;
         clr_end  <= '0;
         fin_row  <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            IDLE: if (in_valid && in_ready) begin
               att <= in_att;
               if (in_chr == 8'h0D) cur_col <= '0;
               else if (in_chr == 8'h08) cur_col <= (cur_col != 7'd0) ? cur_col - 7'd1 : cur_col;
               else begin
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  if (in_chr == 8'h0A) state <= NEWLINE;
                  else if (in_chr == 8'h0C) begin
                     state   <= CLEAR;
                     r       <= '0;
                     c       <= '0;
                     clr_end <= RL;
                     fin_row <= '0;
                     mem_en  <= 1'b1;
                     mem_wr  <= 1'b1;
                     mem_row <= '0;
                     mem_col <= '0;
                     wd      <= {in_att, BLANK_CHR};
                  end else begin
                     state   <= PUT;
                     mem_en  <= 1'b1;
                     mem_wr  <= 1'b1;
                     mem_row <= cur_row;
                     mem_col <= cur_col;
                     wd      <= {in_att, in_chr};
                  end
               end
            end
            PUT: if (cur_col < CL) begin
               cur_col  <= cur_col + 7'd1;
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end else state <= NEWLINE;
            NEWLINE: if (cur_row < RL) begin
               cur_row  <= cur_row + 5'd1;
               cur_col  <= '0;
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end else begin
`ifdef TEXTMODE_WRITER_SCROLL_EN
               state   <= SC_RD;
               r       <= '0;
               c       <= '0;
               fin_row <= RL;
               mem_en  <= 1'b1;
               mem_row <= 5'd1;
               mem_col <= '0;
`else
               state   <= CLEAR;
               r       <= '0;
               c       <= '0;
               clr_end <= '0;
               fin_row <= '0;
               mem_en  <= 1'b1;
               mem_wr  <= 1'b1;
               mem_row <= '0;
               mem_col <= '0;
               wd      <= {att, BLANK_CHR};
`endif
            end
`ifdef TEXTMODE_WRITER_SCROLL_EN
            SC_RD: begin
               state   <= SC_WR;
               mem_en  <= 1'b1;
               mem_wr  <= 1'b1;
               mem_row <= r;
               mem_col <= c;
            end
            SC_WR: if (c == CL && r == RL - 5'd1) begin
               state   <= CLEAR;
               r       <= RL;
               c       <= '0;
               clr_end <= RL;
               mem_en  <= 1'b1;
               mem_wr  <= 1'b1;
               mem_row <= RL;
               mem_col <= '0;
               wd      <= {att, BLANK_CHR};
            end else begin
               state   <= SC_RD;
               r       <= (c == CL) ? r + 5'd1 : r;
               c       <= (c == CL) ? 7'd0 : c + 7'd1;
               mem_en  <= 1'b1;
               mem_row <= (c == CL) ? r + 5'd2 : r + 5'd1;
               mem_col <= (c == CL) ? 7'd0 : c + 7'd1;
            end
`endif
            CLEAR: if (c == CL && r == clr_end) begin
               state    <= IDLE;
               busy     <= 1'b0;
               in_ready <= 1'b1;
               cur_row  <= fin_row;
               cur_col  <= '0;
            end else begin
               r       <= (c == CL) ? r + 5'd1 : r;
               c       <= (c == CL) ? 7'd0 : c + 7'd1;
               mem_en  <= 1'b1;
               mem_wr  <= 1'b1;
               mem_row <= (c == CL) ? r + 5'd1 : r;
               mem_col <= (c == CL) ? 7'd0 : c + 7'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
